sdes_round_sequencer: RTL and testbench
=======================================

# sdes_round_sequencer

Multi-cycle controller that runs one 8-bit block through the complete simplified-DES (S-DES) flow. The flow is key schedule, initial permutation, round 1, swap, round 2, and inverse permutation, with one register stage per step. The block sits between the host-side block interface and the team's combinational permutation/round functions, and owns all sequencing, round-key selection and the encrypt/decrypt key-order swap. Input and output use valid/ready handshakes.

## Interface
Parameters: none. All widths are fixed by S-DES.

- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  host presents block/key/mode
- in_ready  out  1  high only in IDLE
- in_block  in  [0:7]  plaintext or ciphertext; bit 0 = S-DES bit 1 (MSB)
- in_key  in  [0:9]  10-bit key; bit 0 = key bit 1
- in_decrypt  in  1  0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1)
- out_valid  out  1  result held valid until accepted
- out_ready  in  1  host accepts result
- out_block  out  [0:7]  result
- busy  out  1  high in every state except IDLE

## Operation
- All permutation tables are 1-indexed source positions:
  - P10 = 3,5,2,7,4,10,1,9,8,6
  - P8 = 6,3,7,4,8,5,10,9
  - IP = 2,6,3,1,4,8,5,7
  - IP⁻¹ = 4,1,3,5,7,2,8,6
  - EP = 4,1,2,3,2,3,4,1
  - P4 = 2,4,3,1
- Key schedule: P10, split into 5-bit halves.
  - K1 = P8 of both halves rotated left 1.
  - K2 = P8 of both halves rotated left 3 in total (1+2).
- Round fk(L,R,K):
  - t = EP(R) XOR K.
  - S0 takes t[1:4], S1 takes t[5:8]. Row = bits 1,4 of the nibble; column = bits 2,3.
  - Result is L XOR P4(S0‖S1), with R unchanged.
- S-box contents, rows 0–3, columns 0–3:
  - S0 = 1 0 3 2 / 3 2 1 0 / 0 2 1 3 / 3 1 3 2
  - S1 = 0 1 2 3 / 2 0 1 3 / 3 0 1 0 / 2 1 0 3
- FSM states and register updates:
  - IDLE: in_ready=1. On in_valid, capture block, key and mode into registers and go to KEYGEN.
  - KEYGEN: register ka = first-round key and kb = second-round key, swapped if mode is decrypt. Go to IPERM.
  - IPERM: data ← IP(data). Go to RND1.
  - RND1: data ← fk(data, ka). Go to SWAP.
  - SWAP: data ← {data[4:7], data[0:3]}. Go to RND2.
  - RND2: data ← fk(data, kb). Go to FPERM.
  - FPERM: out_block register ← IP⁻¹(data). Go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE. Otherwise hold, with out_block stable.
- Inputs are sampled only on the accept edge. Changes to in_* while busy are ignored.
- in_valid and out_ready are never both relevant in one state, so there is no simultaneous-event conflict. A new accept is impossible while in DONE.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_block = 0x00. Internal data, key and round-key registers are all 0.

## Timing
- Accept on edge A (in_valid & in_ready). Then KEYGEN@A+1, IPERM@A+2, RND1@A+3, SWAP@A+4, RND2@A+5, FPERM@A+6.
- out_valid rises after edge A+6, i.e. result latency is 6 cycles.
- With out_ready held high, DONE lasts 1 cycle. in_ready returns after edge A+7 and the next accept is possible at edge A+8, giving a throughput of 1 block per 8 cycles.
- out_valid deasserts on the edge that completes the out_ready handshake.
- rst asserted in any state, including mid-round or in DONE with out_valid high, forces reset values on the next edge. The in-flight block is discarded with no output.
- in_valid and in_ready are not combinationally dependent on each other. in_ready, out_valid and busy are decoded from registered state only.

## Test plan
- Encrypt known answer: key 1010000010, block 10010111, decrypt=0 → internal K1 = 10100100, K2 = 01000011; out_block = 00111000 with out_valid exactly 6 cycles after accept.
- Decrypt known answer: key 1010000010, block 00111000, decrypt=1 → out_block = 10010111.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_block stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready → next cycle out_valid=0, in_ready=1.
- Input isolation: change in_block/in_key every cycle while busy → result equals the value computed from the accept-cycle sample only.
- Reset mid-operation: assert rst during RND1 → next cycle out_valid=0, busy=0, in_ready=1, out_block=0x00. A fresh encrypt then produces the correct known answer.
- Random round-trip: 1000 random key/block pairs, encrypt then decrypt with the same key → original block returned each time, with the encrypt result matching the reference model.

Source files
------------

// File: rtl/sdes_round_sequencer_if.sv
// Block-level handshake bundle between the host and the S-DES round sequencer.
// Both directions are valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface sdes_round_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_block;
    logic [0:9] in_key;
    logic       in_decrypt;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_block;
    logic       busy;

    modport slave (
        input  in_valid, in_block, in_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_block, busy
    );

    modport master (
        output in_valid, in_block, in_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_block, busy
    );
endinterface

// File: rtl/sdes_round_sequencer.sv
// Sequences one 8-bit block through key schedule, IP, fk, swap, fk and IP^-1, one register stage per step.
// Bit 0 of every vector is S-DES bit 1, so permutation tables map directly onto ascending indices.
module sdes_round_sequencer (
    input  logic                          clk,
    input  logic                          rst,
    sdes_round_sequencer_if.slave         bus,
    output logic [2:0]                    dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_KEYGEN, S_IPERM, S_RND1, S_SWAP, S_RND2, S_FPERM, S_DONE
    } state_t;

    localparam logic [1:0] s0_tbl [16] = '{2'd1, 2'd0, 2'd3, 2'd2,  2'd3, 2'd2, 2'd1, 2'd0,
                                           2'd0, 2'd2, 2'd1, 2'd3,  2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] s1_tbl [16] = '{2'd0, 2'd1, 2'd2, 2'd3,  2'd2, 2'd0, 2'd1, 2'd3,
                                           2'd3, 2'd0, 2'd1, 2'd0,  2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [0:9] p10(input logic [0:9] k);
        return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    endfunction

    function automatic logic [0:7] p8(input logic [0:9] k);
        return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
    endfunction

    function automatic logic [0:7] ip(input logic [0:7] d);
        return {d[1], d[5], d[2], d[0], d[3], d[7], d[4], d[6]};
    endfunction

    function automatic logic [0:7] ip_inv(input logic [0:7] d);
        return {d[3], d[0], d[2], d[4], d[6], d[1], d[7], d[5]};
    endfunction

    function automatic logic [0:4] rol1(input logic [0:4] h);
        return {h[1:4], h[0]};
    endfunction

    // Row comes from the outer nibble bits, column from the inner pair.
    function automatic logic [0:7] fk(input logic [0:7] d, input logic [0:7] k);
        logic [0:7] t;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [0:3] sb;
        logic [0:3] p;
        t  = {d[7], d[4], d[5], d[6], d[5], d[6], d[7], d[4]} ^ k;
        s0 = s0_tbl[{t[0], t[3], t[1], t[2]}];
        s1 = s1_tbl[{t[4], t[7], t[5], t[6]}];
        sb = {s0, s1};
        p  = {sb[1], sb[3], sb[2], sb[0]};
        return {d[0:3] ^ p, d[4:7]};
    endfunction

    state_t     state;
    state_t     state_nx;
    logic [0:7] data_q;
    logic [0:7] out_q;
    logic [0:7] ka_q;
    logic [0:7] kb_q;
    logic [0:9] key_q;
    logic       dec_q;
    logic [0:9] key_p;
    logic [0:4] l1;
    logic [0:4] r1;
    logic [0:7] k1;
    logic [0:7] k2;

    always_comb begin
        key_p = p10(key_q);
        l1    = rol1(key_p[0:4]);
        r1    = rol1(key_p[5:9]);
        k1    = p8({l1, r1});
        k2    = p8({rol1(rol1(l1)), rol1(rol1(r1))});
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.in_valid) state_nx = S_KEYGEN;
            S_KEYGEN: state_nx = S_IPERM;
            S_IPERM:  state_nx = S_RND1;
            S_RND1:   state_nx = S_SWAP;
            S_SWAP:   state_nx = S_RND2;
            S_RND2:   state_nx = S_FPERM;
            S_FPERM:  state_nx = S_DONE;
            S_DONE:   if (bus.out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            data_q <= '0;
            out_q  <= '0;
            ka_q   <= '0;
            kb_q   <= '0;
            key_q  <= '0;
            dec_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    data_q <= bus.in_block;
                    key_q  <= bus.in_key;
                    dec_q  <= bus.in_decrypt;
                end
                S_KEYGEN: begin
                    ka_q <= dec_q ? k2 : k1;
                    kb_q <= dec_q ? k1 : k2;
                end
                S_IPERM: data_q <= ip(data_q);
                S_RND1:  data_q <= fk(data_q, ka_q);
                S_SWAP:  data_q <= {data_q[4:7], data_q[0:3]};
                S_RND2:  data_q <= fk(data_q, kb_q);
                S_FPERM: out_q  <= ip_inv(data_q);
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_block = out_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_sdes_round_sequencer.sv
// Directed and round-trip bench for sdes_round_sequencer against a table-driven S-DES model.
module tb_sdes_round_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_pass   = 0;

    sdes_round_sequencer_if intf ();

    sdes_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (intf.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int t_p10 [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int t_p8  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int t_ip  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int t_ipi [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int t_ep  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int t_p4  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int s0_t [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int s1_t [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    // Model values are MSB-first: S-DES bit p of an n-bit value sits at position n-p.
    function automatic logic [9:0] perm(input logic [9:0] v, input int n_in, input int tbl [10], input int n_out);
        logic [9:0] r = '0;
        for (int i = 0; i < n_out; i++) r[n_out - 1 - i] = v[n_in - tbl[i]];
        return r;
    endfunction

    function automatic logic [4:0] rol(input logic [4:0] x, input int n);
        return 5'((x << n) | (x >> (5 - n)));
    endfunction

    function automatic logic [7:0] ref_key(input logic [9:0] key, input bit second);
        logic [9:0] p;
        logic [9:0] k;
        int         sh;
        p  = perm(key, 10, t_p10, 10);
        sh = second ? 3 : 1;
        k  = perm({rol(p[9:5], sh), rol(p[4:0], sh)}, 10, t_p8, 8);
        return k[7:0];
    endfunction

    function automatic logic [7:0] ref_fk(input logic [7:0] d, input logic [7:0] k);
        logic [9:0] e;
        logic [9:0] p;
        logic [7:0] t;
        int         a0;
        int         a1;
        e  = perm({6'd0, d[3:0]}, 4, t_ep, 8);
        t  = e[7:0] ^ k;
        a0 = s0_t[{t[7], t[4]}][{t[6], t[5]}];
        a1 = s1_t[{t[3], t[0]}][{t[2], t[1]}];
        p  = perm({6'd0, 2'(a0), 2'(a1)}, 4, t_p4, 4);
        return {d[7:4] ^ p[3:0], d[3:0]};
    endfunction

    function automatic logic [7:0] ref_sdes(input logic [9:0] key, input logic [7:0] blk, input bit dec);
        logic [9:0] d;
        logic [7:0] x;
        d = perm({2'd0, blk}, 8, t_ip, 8);
        x = ref_fk(d[7:0], ref_key(key, dec));
        x = {x[3:0], x[7:4]};
        x = ref_fk(x, ref_key(key, !dec));
        d = perm({2'd0, x}, 8, t_ipi, 8);
        return d[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_accept(input logic [9:0] key, input logic [7:0] blk, input bit dec);
        @(negedge clk);
        intf.in_key     = key;
        intf.in_block   = blk;
        intf.in_decrypt = dec;
        intf.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        intf.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, input bit scramble);
        lat = 0;
        while (!intf.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (scramble) begin
                intf.in_block   = 8'($urandom_range(0, 255));
                intf.in_key     = 10'($urandom_range(0, 1023));
                intf.in_decrypt = 1'($urandom_range(0, 1));
            end
        end
        if (!intf.out_valid) check("done_timeout", 32'(intf.out_valid), 32'd1);
    endtask

    task automatic finish_out;
        intf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        intf.out_ready = 1'b0;
    endtask

    task automatic run_block(input logic [9:0] key, input logic [7:0] blk, input bit dec,
                             output logic [7:0] res, output int lat);
        do_accept(key, blk, dec);
        wait_done(lat, 1'b0);
        res = intf.out_block;
        finish_out();
    endtask

    initial begin
        logic [7:0] res;
        logic [7:0] enc;
        logic [7:0] held;
        logic [9:0] key;
        logic [7:0] blk;
        int         lat;

        intf.in_valid   = 1'b0;
        intf.in_block   = '0;
        intf.in_key     = '0;
        intf.in_decrypt = 1'b0;
        intf.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(intf.in_ready),  32'd1);
        check("rst_out_valid", 32'(intf.out_valid), 32'd0);
        check("rst_busy",      32'(intf.busy),      32'd0);
        check("rst_out_block", 32'(intf.out_block), 32'h00);
        check("rst_state",     32'(dbg_state),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Encrypt known answer with exact latency and internal round keys.
        do_accept(10'b1010000010, 8'b10010111, 1'b0);
        check("acc_busy",     32'(intf.busy),     32'd1);
        check("acc_in_ready", 32'(intf.in_ready), 32'd0);
        wait_done(lat, 1'b0);
        check("enc_latency", 32'(lat), 32'd6);
        check("enc_k1", 32'(dut.ka_q), 32'b10100100);
        check("enc_k2", 32'(dut.kb_q), 32'b01000011);
        check("enc_kat", 32'(intf.out_block), 32'b00111000);
        finish_out();
        check("enc_release_valid", 32'(intf.out_valid), 32'd0);
        check("enc_release_ready", 32'(intf.in_ready),  32'd1);

        run_block(10'b1010000010, 8'b00111000, 1'b1, res, lat);
        check("dec_kat", 32'(res), 32'b10010111);
        check("dec_ka",  32'(dut.ka_q), 32'b01000011);
        check("dec_latency", 32'(lat), 32'd6);

        // Backpressure: result held while in_valid pulses are ignored.
        do_accept(10'h2c5, 8'h5a, 1'b0);
        wait_done(lat, 1'b0);
        held = intf.out_block;
        check("bp_first", 32'(held), 32'(ref_sdes(10'h2c5, 8'h5a, 1'b0)));
        for (int i = 0; i < 10; i++) begin
            intf.in_valid = 1'(i % 2);
            intf.in_block = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            check("bp_block",     32'(intf.out_block), 32'(held));
            check("bp_valid",     32'(intf.out_valid), 32'd1);
            check("bp_in_ready",  32'(intf.in_ready),  32'd0);
        end
        intf.in_valid = 1'b0;
        finish_out();
        check("bp_release_valid", 32'(intf.out_valid), 32'd0);
        check("bp_release_ready", 32'(intf.in_ready),  32'd1);

        // Input isolation: inputs scrambled every cycle while busy.
        do_accept(10'h1b3, 8'hc4, 1'b0);
        wait_done(lat, 1'b1);
        check("iso_result", 32'(intf.out_block), 32'(ref_sdes(10'h1b3, 8'hc4, 1'b0)));
        finish_out();
        do_accept(10'h0f0, 8'h3e, 1'b1);
        wait_done(lat, 1'b1);
        check("iso_dec_result", 32'(intf.out_block), 32'(ref_sdes(10'h0f0, 8'h3e, 1'b1)));
        finish_out();

        // Reset while in RND1 discards the block.
        do_accept(10'h3ff, 8'h81, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_state_rnd1", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_out_valid", 32'(intf.out_valid), 32'd0);
        check("mid_busy",      32'(intf.busy),      32'd0);
        check("mid_in_ready",  32'(intf.in_ready),  32'd1);
        check("mid_out_block", 32'(intf.out_block), 32'h00);
        run_block(10'b1010000010, 8'b10010111, 1'b0, res, lat);
        check("mid_fresh_kat", 32'(res), 32'b00111000);

        for (int i = 0; i < 1000; i++) begin
            key = 10'($urandom_range(0, 1023));
            blk = 8'($urandom_range(0, 255));
            run_block(key, blk, 1'b0, enc, lat);
            check("rnd_encrypt", 32'(enc), 32'(ref_sdes(key, blk, 1'b0)));
            run_block(key, enc, 1'b1, res, lat);
            check("rnd_roundtrip", 32'(res), 32'(blk));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
